// File: rtl/axi4_full_slave_mem_if.sv
// AXI4-Full channel bundle between the burst master and the memory-backed slave.
// Lock/cache/prot/qos/region/user are deliberately absent.
interface axi4_full_slave_mem_if #(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
);
  logic [ID_WIDTH-1:0]         awid;
  logic [ADDR_BUS_WIDTH-1:0]   awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BUS_WIDTH-1:0]   wdata;
  logic [DATA_BUS_WIDTH/8-1:0] wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  logic [ID_WIDTH-1:0]         bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ID_WIDTH-1:0]         arid;
  logic [ADDR_BUS_WIDTH-1:0]   araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  logic [ID_WIDTH-1:0]         rid;
  logic [DATA_BUS_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_full_slave_mem.sv
// AXI4-Full memory-backed slave: one outstanding write and one outstanding read burst,
// word-addressed RAM behind independent write and read FSMs.
module axi4_full_slave_mem #(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter logic [ADDR_BUS_WIDTH-1:0] TARGET_SLAVE_BASE_ADDR = ADDR_BUS_WIDTH'(32'h1000_0000)
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  axi4_full_slave_mem_if.slave  s_axi
);
  localparam int         STRB_W      = DATA_BUS_WIDTH / 8;
  localparam int         ADDR_LSB    = $clog2(STRB_W);
  localparam int         IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [2:0] SIZE_NAT    = 3'(ADDR_LSB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_DATA = 2'd2} r_state_t;

  function automatic logic [1:0] burst_check(input logic [ADDR_BUS_WIDTH-1:0] addr,
                                             input logic [7:0] len, input logic [2:0] size,
                                             input logic [1:0] burst);
    logic [ADDR_BUS_WIDTH:0] last_idx;
    logic [1:0]              resp;
    last_idx = {1'b0, (addr - TARGET_SLAVE_BASE_ADDR) >> ADDR_LSB} + (ADDR_BUS_WIDTH+1)'(len);
    if (addr < TARGET_SLAVE_BASE_ADDR) resp = RESP_DECERR;
    else if (last_idx >= (ADDR_BUS_WIDTH+1)'(MEM_DEPTH)) resp = RESP_DECERR;
    else if (size != SIZE_NAT || (burst != BURST_FIXED && burst != BURST_INCR)) resp = RESP_SLVERR;
    else resp = RESP_OKAY;
    return resp;
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_BUS_WIDTH-1:0] addr);
    logic [ADDR_BUS_WIDTH-1:0] off;
    off = (addr - TARGET_SLAVE_BASE_ADDR) >> ADDR_LSB;
    return IDX_W'(off);
  endfunction

  logic [DATA_BUS_WIDTH-1:0] mem [MEM_DEPTH];
  logic                      init_r;

  w_state_t            w_state_r, w_state_n;
  logic [ID_WIDTH-1:0] w_id_r;
  logic [IDX_W-1:0]    w_idx_r;
  logic [7:0]          w_len_r, w_beat_r;
  logic [1:0]          w_err_r, bresp_r;
  logic                w_incr_r, w_over_r, awready_r, wready_r, bvalid_r;
  logic                aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s, we_s;

  r_state_t                  r_state_r, r_state_n;
  logic [ID_WIDTH-1:0]       r_id_r;
  logic [IDX_W-1:0]          r_idx_r, r_idx_nxt_s;
  logic [7:0]                r_len_r, r_beat_r;
  logic [1:0]                r_err_r;
  logic [DATA_BUS_WIDTH-1:0] rdata_r;
  logic                      r_incr_r, rlast_r, rvalid_r, arready_r, ar_hs_s, r_hs_s;

  assign aw_hs_s       = s_axi.awvalid & awready_r;
  assign w_hs_s        = s_axi.wvalid & wready_r;
  assign b_hs_s        = bvalid_r & s_axi.bready;
  assign w_last_beat_s = (w_beat_r == w_len_r);
  assign we_s          = w_hs_s & (w_err_r == RESP_OKAY) & ~w_over_r;
  assign ar_hs_s       = s_axi.arvalid & arready_r;
  assign r_hs_s        = rvalid_r & s_axi.rready;
  assign r_idx_nxt_s   = r_incr_r ? (r_idx_r + IDX_W'(1'b1)) : r_idx_r;

  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bid     = w_id_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rid     = r_id_r;
  assign s_axi.rresp   = r_err_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rlast   = rlast_r;

  // State registers; init_r holds the address channels closed for one edge after reset.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      init_r    <= 1'b0;
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
    end else begin
      init_r    <= 1'b1;
      w_state_r <= w_state_n;
      r_state_r <= r_state_n;
    end
  end

  // Write FSM next state.
  always_comb begin
    w_state_n = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_state_n = W_DATA; else w_state_n = W_IDLE;
      W_DATA:  if (w_hs_s && s_axi.wlast) w_state_n = W_RESP; else w_state_n = W_DATA;
      W_RESP:  if (b_hs_s) w_state_n = W_IDLE; else w_state_n = W_RESP;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_n = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_state_n = R_LOAD; else r_state_n = R_IDLE;
      R_LOAD:  r_state_n = R_DATA;
      R_DATA:  if (r_hs_s && rlast_r) r_state_n = R_IDLE; else r_state_n = R_DATA;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Write channel handshakes, burst capture and response; overrun beats are flagged, not written.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      w_id_r    <= {ID_WIDTH{1'b0}};
      w_idx_r   <= {IDX_W{1'b0}};
      w_len_r   <= 8'd0;
      w_beat_r  <= 8'd0;
      w_err_r   <= RESP_OKAY;
      w_incr_r  <= 1'b0;
      w_over_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      awready_r <= init_r & (w_state_n == W_IDLE);
      wready_r  <= (w_state_n == W_DATA);
      bvalid_r  <= (w_state_n == W_RESP);
      if (aw_hs_s) begin
        w_id_r   <= s_axi.awid;
        w_idx_r  <= word_index(s_axi.awaddr);
        w_len_r  <= s_axi.awlen;
        w_incr_r <= (s_axi.awburst == BURST_INCR);
        w_err_r  <= burst_check(s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst);
        w_beat_r <= 8'd0;
        w_over_r <= 1'b0;
      end
      if (w_hs_s) begin
        w_beat_r <= w_beat_r + 8'd1;
        if (w_incr_r) w_idx_r <= w_idx_r + IDX_W'(1'b1);
        if (w_last_beat_s && !s_axi.wlast) w_over_r <= 1'b1;
        if (s_axi.wlast) begin
          if (w_err_r != RESP_OKAY) bresp_r <= w_err_r;
          else if (w_over_r || !w_last_beat_s) bresp_r <= RESP_SLVERR;
          else bresp_r <= RESP_OKAY;
        end
      end
    end
  end

  // RAM byte-lane writes; contents intentionally survive reset.
  always_ff @(posedge s_axi_aclk) begin
    if (we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx_r][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // Read channel: prefetch the next word on each accepted beat so rvalid never bubbles.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= {DATA_BUS_WIDTH{1'b0}};
      r_id_r    <= {ID_WIDTH{1'b0}};
      r_idx_r   <= {IDX_W{1'b0}};
      r_len_r   <= 8'd0;
      r_beat_r  <= 8'd0;
      r_err_r   <= RESP_OKAY;
      r_incr_r  <= 1'b0;
    end else begin
      arready_r <= init_r & (r_state_n == R_IDLE);
      rvalid_r  <= (r_state_n == R_DATA);
      if (ar_hs_s) begin
        r_id_r   <= s_axi.arid;
        r_idx_r  <= word_index(s_axi.araddr);
        r_len_r  <= s_axi.arlen;
        r_incr_r <= (s_axi.arburst == BURST_INCR);
        r_err_r  <= burst_check(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
        r_beat_r <= 8'd0;
      end
      if (r_state_r == R_LOAD) begin
        rdata_r <= (r_err_r == RESP_OKAY) ? mem[r_idx_r] : {DATA_BUS_WIDTH{1'b0}};
        rlast_r <= (r_len_r == 8'd0);
      end
      if (r_hs_s) begin
        if (rlast_r) begin
          rlast_r <= 1'b0;
        end else begin
          r_idx_r  <= r_idx_nxt_s;
          r_beat_r <= r_beat_r + 8'd1;
          rdata_r  <= (r_err_r == RESP_OKAY) ? mem[r_idx_nxt_s] : {DATA_BUS_WIDTH{1'b0}};
          rlast_r  <= ((r_beat_r + 8'd1) == r_len_r);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// Directed plus randomized bench for axi4_full_slave_mem against a word-array memory model.
module tb_axi4_full_slave_mem;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_full_slave_mem_if #(.ID_WIDTH(4), .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) bus ();

  axi4_full_slave_mem #(
    .ID_WIDTH(4), .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .MEM_DEPTH(1024),
    .TARGET_SLAVE_BASE_ADDR(BASE)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] ref_mem [1024];
  bit          ref_ok  [1024];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response a burst deserves from its address, length, size and type alone.
  function automatic logic [1:0] model_resp(input logic [31:0] addr, input int len,
                                            input int size, input int burst);
    int idx;
    if (addr < BASE) return 2'b11;
    idx = int'((addr - BASE) >> 2);
    if (idx + len >= 1024) return 2'b11;
    if (size != 2 || burst > 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input int size, input int burst, input int nbeats);
    logic [1:0] r;
    int idx;
    r = model_resp(addr, len, size, burst);
    if (r == 2'b00) begin
      for (int b = 0; b < nbeats && b <= len; b++) begin
        idx = int'((addr - BASE) >> 2) + ((burst == 1) ? b : 0);
        for (int k = 0; k < 4; k++) if (ws[b][k]) ref_mem[idx][8*k +: 8] = wd[b][8*k +: 8];
        if (ws[b] == 4'hF) ref_ok[idx] = 1'b1;
      end
      if (nbeats != len + 1) r = 2'b10;
    end
    return r;
  endfunction

  task automatic aw_phase(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    int t;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.awready && t < 100) begin @(negedge clk); t++; end
    chk({tag, "/aw_wait"}, (t < 100), 64'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    chk({tag, "/wready_after_aw"}, bus.wready, 64'd1);
  endtask

  task automatic w_beat(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
    int t;
    bus.wdata = d; bus.wstrb = s; bus.wlast = l; bus.wvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.wready && t < 100) begin @(negedge clk); t++; end
    chk({tag, "/w_wait"}, (t < 100), 64'd1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                          input int nbeats, input int bdelay);
    logic [1:0] exp_resp, got_resp;
    logic [3:0] got_id;
    int t;
    exp_resp = model_write(addr, int'(len), int'(size), int'(burst), nbeats);
    aw_phase(tag, addr, len, size, burst, id);
    for (int b = 0; b < nbeats; b++) w_beat(tag, wd[b], ws[b], (b == nbeats - 1));
    chk({tag, "/bvalid_after_wlast"}, bus.bvalid, 64'd1);
    got_resp = bus.bresp;
    got_id   = bus.bid;
    repeat (bdelay) begin
      @(negedge clk);
      chk({tag, "/bvalid_hold"}, {bus.bvalid, bus.bid, bus.bresp}, {1'b1, got_id, got_resp});
    end
    bus.bready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.bvalid && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus.bready = 1'b0;
    chk({tag, "/bresp"}, got_resp, exp_resp);
    chk({tag, "/bid"}, got_id, id);
    chk({tag, "/aw_ready_after_b"}, {bus.awready, bus.bvalid}, 2'b10);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                         input bit toggle);
    logic [1:0]  exp_resp;
    logic [31:0] hold_d;
    logic        hold_l;
    int t, beat, idx, base_idx, ar_cyc, first_cyc, last_cyc;
    bit seen, stalled;
    exp_resp = model_resp(addr, int'(len), int'(size), int'(burst));
    base_idx = int'((addr - BASE) >> 2);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1; bus.rready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.arready && t < 100) begin @(negedge clk); t++; end
    chk({tag, "/ar_wait"}, (t < 100), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    ar_cyc = cyc; first_cyc = 0; last_cyc = 0;
    beat = 0; t = 0; seen = 1'b0; stalled = 1'b0;
    while (beat <= int'(len) && t < 2000) begin
      @(negedge clk); t++;
      bus.rready = toggle ? (t % 2 == 1) : 1'b1;
      if (stalled) chk({tag, "/r_hold"}, {bus.rvalid, bus.rlast, bus.rdata}, {1'b1, hold_l, hold_d});
      if (bus.rvalid) begin
        if (!seen) begin
          chk({tag, "/first_rvalid_latency"}, cyc - ar_cyc, 64'd1);
          seen = 1'b1; first_cyc = cyc;
        end
        if (bus.rready) begin
          chk({tag, "/rresp_rid_rlast"}, {bus.rresp, bus.rid, bus.rlast},
              {exp_resp, id, (beat == int'(len))});
          if (exp_resp != 2'b00) chk({tag, "/rdata_err"}, bus.rdata, 64'd0);
          else begin
            idx = base_idx + ((burst == 2'b01) ? beat : 0);
            if (ref_ok[idx]) chk({tag, "/rdata"}, bus.rdata, ref_mem[idx]);
          end
          last_rdata = bus.rdata;
          last_cyc = cyc; beat++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_d = bus.rdata; hold_l = bus.rlast;
        end
      end
    end
    chk({tag, "/beat_count"}, beat, int'(len) + 1);
    if (!toggle) chk({tag, "/no_bubbles"}, last_cyc - first_cyc, int'(len));
    @(posedge clk); #1;
    bus.rready = 1'b0;
    chk({tag, "/ar_ready_after_rlast"}, {bus.arready, bus.rvalid}, 2'b10);
  endtask

  initial begin
    logic [31:0] a;
    int len;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values, then the one-edge delay before the address channels open.
    repeat (2) @(negedge clk);
    chk("rst/hold", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 6'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst/edge1_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 6'd0);
    chk("rst/edge1_data", {bus.bid, bus.bresp, bus.rid, bus.rresp, bus.rdata}, 64'd0);
    @(posedge clk); #1;
    chk("rst/edge2_ready", {bus.awready, bus.arready}, 2'b11);

    for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
    do_write("incr16", BASE, 8'd15, 3'd2, 2'b01, 4'h3, 16, 0);
    do_read("incr16", BASE, 8'd15, 3'd2, 2'b01, 4'h5, 1'b0);

    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write("strb_pre", BASE + 32'h100, 8'd0, 3'd2, 2'b01, 4'h1, 1, 0);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0011;
    do_write("strb", BASE + 32'h100, 8'd0, 3'd2, 2'b01, 4'h2, 1, 0);
    do_read("strb", BASE + 32'h100, 8'd0, 3'd2, 2'b01, 4'h2, 1'b0);
    chk("strb/merged_word", last_rdata, 32'h1122_CCDD);

    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write("below_base", 32'h0FFF_FFF0, 8'd0, 3'd2, 2'b01, 4'h4, 1, 0);
    do_read("below_base", 32'h0FFF_FFF0, 8'd7, 3'd2, 2'b01, 4'h4, 1'b0);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write("top_pre", BASE + 32'd4080, 8'd3, 3'd2, 2'b01, 4'h6, 4, 0);
    for (int i = 0; i < 8; i++) wd[i] = ~wd[i];
    do_write("top_over", BASE + 32'd4080, 8'd7, 3'd2, 2'b01, 4'h7, 8, 0);
    do_read("top_keep", BASE + 32'd4080, 8'd3, 3'd2, 2'b01, 4'h7, 1'b0);
    do_read("top_over", BASE + 32'd4080, 8'd7, 3'd2, 2'b01, 4'h8, 1'b0);

    do_write("wrap_burst", BASE + 32'h200, 8'd1, 3'd2, 2'b10, 4'h9, 2, 0);
    do_read("bad_size", BASE, 8'd1, 3'd1, 2'b01, 4'h9, 1'b0);
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write("fixed4", BASE + 32'd1200, 8'd3, 3'd2, 2'b00, 4'hA, 4, 0);
    do_read("fixed4", BASE + 32'd1200, 8'd0, 3'd2, 2'b01, 4'hA, 1'b0);
    chk("fixed4/last_value", last_rdata, 32'd4);
    do_read("fixed_rd", BASE + 32'd1200, 8'd3, 3'd2, 2'b00, 4'hA, 1'b0);
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    do_write("early_wlast", BASE + 32'd1600, 8'd3, 3'd2, 2'b01, 4'hB, 3, 0);
    do_read("early_wlast", BASE + 32'd1600, 8'd2, 3'd2, 2'b01, 4'hB, 1'b0);
    do_write("late_pre", BASE + 32'd1640, 8'd2, 3'd2, 2'b01, 4'hC, 3, 0);
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    do_write("no_wlast", BASE + 32'd1640, 8'd1, 3'd2, 2'b01, 4'hC, 3, 0);
    do_read("no_wlast", BASE + 32'd1640, 8'd2, 3'd2, 2'b01, 4'hC, 1'b0);

    repeat (6) begin
      len = $urandom_range(0, 15);
      a   = BASE + 32'($urandom_range(500, 900)) * 32'd4;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(1, 15)); end
      do_write("rand", a, 8'(len), 3'd2, 2'b01, 4'($urandom), len + 1, int'($urandom_range(0, 3)));
      do_read("rand", a, 8'(len), 3'd2, 2'b01, 4'($urandom), 1'b0);
    end

    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_read("conc_rd", BASE, 8'd15, 3'd2, 2'b01, 4'hD, 1'b1);
      do_write("conc_wr", BASE + 32'd2400, 8'd15, 3'd2, 2'b01, 4'hE, 16, 5);
    join
    do_read("conc_chk", BASE + 32'd2400, 8'd15, 3'd2, 2'b01, 4'hE, 1'b0);

    // Reset lands while beat 5 of a 16-beat write is being offered.
    for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    aw_phase("rst_mid", BASE + 32'd2800, 8'd15, 3'd2, 2'b01, 4'h1);
    for (int b = 0; b < 5; b++) begin
      w_beat("rst_mid", wd[b], 4'hF, 1'b0);
      ref_mem[700 + b] = wd[b]; ref_ok[700 + b] = 1'b1;
    end
    bus.wdata = wd[5]; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid/hold", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 6'd0);
    bus.wvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid/edge1", {bus.awready, bus.arready, bus.wready}, 3'b000);
    @(posedge clk); #1;
    chk("rst_mid/edge2", {bus.awready, bus.arready}, 2'b11);
    do_read("rst_mid_partial", BASE + 32'd2800, 8'd4, 3'd2, 2'b01, 4'h2, 1'b0);
    for (int i = 0; i < 16; i++) wd[i] = $urandom;
    do_write("after_rst", BASE + 32'd2880, 8'd15, 3'd2, 2'b01, 4'h3, 16, 0);
    do_read("after_rst", BASE + 32'd2880, 8'd15, 3'd2, 2'b01, 4'h3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
